// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered full/empty/almost flags,
// fill count and sticky overflow/underflow indicators.
// Latency: a write is visible in flags/fcount after one edge; read data
// arrives one cycle after the pop (FWFT=0) or is presented at the head (FWFT=1).
// Backpressure: writes are refused while wfull=1 and reads while rempty=1;
// refused requests only set the matching sticky error flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of pointers, count, flags, errors
//   wdata, win          write data and write request
//   wfull, afull        full (count == DEPTH) / almost full (count >= AFULL_TH)
//   rout, rdata         read request and read data
//   rempty, aempty      empty (count == 0) / almost empty (count <= AEMPTY_TH)
//   fcount              fill count, 0..DEPTH
//   overflow, underflow sticky error indicators
module sync_fifo_flags #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int AFULL_TH  = (2**ASIZE) - 2,
   parameter int AEMPTY_TH = 2,
   parameter bit FWFT      = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [DSIZE-1:0] wdata,
   input  logic             win,
   output logic             wfull,
   output logic             afull,
   input  logic             rout,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             aempty,
   output logic [ASIZE:0]   fcount,
   output logic             overflow,
   output logic             underflow
);

   localparam int DEPTH = 2**ASIZE;
   localparam logic [ASIZE:0] DEPTH_V  = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AFULL_V  = (ASIZE+1)'(AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_V = (ASIZE+1)'(AEMPTY_TH);

   logic [DSIZE-1:0] mem [DEPTH];

   logic [ASIZE:0] wptr, rptr;
   logic [ASIZE:0] wptr_nxt, rptr_nxt, count_nxt;
   logic           wr_acc, rd_acc;

   // Acceptance looks only at the registered flags, so a same-cycle pop
   // never frees room for a push at full (and vice versa at empty).
   assign wr_acc = win  & ~wfull;
   assign rd_acc = rout & ~rempty;

   always_comb begin
      wptr_nxt = wptr;
      rptr_nxt = rptr;
      if (flush) begin
         wptr_nxt = '0;
         rptr_nxt = '0;
      end else begin
         if (wr_acc) wptr_nxt = wptr + 1'b1;
         if (rd_acc) rptr_nxt = rptr + 1'b1;
      end
      // Pointers run modulo 2*DEPTH, so their difference is the exact fill
      // level 0..DEPTH without a separate full/empty disambiguation bit.
      count_nxt = wptr_nxt - rptr_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         fcount    <= '0;
         wfull     <= 1'b0;
         afull     <= 1'b0;
         rempty    <= 1'b1;
         aempty    <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wptr   <= wptr_nxt;
         rptr   <= rptr_nxt;
         fcount <= count_nxt;
         // Flags are derived from the next count so they always agree with fcount.
         wfull  <= (count_nxt == DEPTH_V);
         afull  <= (count_nxt >= AFULL_V);
         rempty <= (count_nxt == '0);
         aempty <= (count_nxt <= AEMPTY_V);
         if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (win  && wfull)  overflow  <= 1'b1;
            if (rout && rempty) underflow <= 1'b1;
         end
      end
   end

   // Storage is never reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (!flush && wr_acc) mem[wptr[ASIZE-1:0]] <= wdata;
   end

   generate
      if (FWFT) begin : g_fwft
         // Head entry is presented directly; undefined while empty.
         assign rdata = mem[rptr[ASIZE-1:0]];
      end else begin : g_std
         logic [DSIZE-1:0] rdata_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                rdata_q <= '0;
            else if (!flush && rd_acc) rdata_q <= mem[rptr[ASIZE-1:0]];
         end
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [7:0] wdata;
   logic       win;
   logic       rout;

   logic       wfull0, afull0, rempty0, aempty0, ovf0, unf0;
   logic       wfull1, afull1, rempty1, aempty1, ovf1, unf1;
   logic [7:0] rdata0, rdata1;
   logic [2:0] fcount0, fcount1;

   int n_chk = 0;
   int n_err = 0;

   // reference model: queue contents plus sticky bits and standard-mode read data
   logic [7:0] q[$];
   bit         m_ovf, m_unf;
   logic [7:0] m_rd0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DSIZE(8), .ASIZE(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1'b0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .win(win),
      .wfull(wfull0), .afull(afull0), .rout(rout), .rdata(rdata0),
      .rempty(rempty0), .aempty(aempty0), .fcount(fcount0),
      .overflow(ovf0), .underflow(unf0)
   );

   sync_fifo_flags #(.DSIZE(8), .ASIZE(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .win(win),
      .wfull(wfull1), .afull(afull1), .rout(rout), .rdata(rdata1),
      .rempty(rempty1), .aempty(aempty1), .fcount(fcount1),
      .overflow(ovf1), .underflow(unf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("fcount",    32'(fcount0), 32'(n));
      chk("wfull",     32'(wfull0),  32'(n == DEPTH));
      chk("afull",     32'(afull0),  32'(n >= 3));
      chk("rempty",    32'(rempty0), 32'(n == 0));
      chk("aempty",    32'(aempty0), 32'(n <= 1));
      chk("overflow",  32'(ovf0),    32'(m_ovf));
      chk("underflow", 32'(unf0),    32'(m_unf));
      chk("rdata",     32'(rdata0),  32'(m_rd0));
      chk("fwft_fcount", 32'({fcount1, wfull1, afull1, rempty1, aempty1, ovf1, unf1}),
                         32'({fcount0, wfull0, afull0, rempty0, aempty0, ovf0, unf0}));
      if (n > 0) chk("fwft_rdata", 32'(rdata1), 32'(q[0]));
   endtask

   // one clock cycle: drive, advance the model with pre-edge state, check after edge
   task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic f);
      logic [7:0] tmp;
      win = w; wdata = wd; rout = r; flush = f;
      if (f) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         bit wacc, racc;
         wacc = w && (q.size() < DEPTH);
         racc = r && (q.size() > 0);
         if (w && !wacc) m_ovf = 1'b1;
         if (r && !racc) m_unf = 1'b1;
         if (racc) begin
            tmp = q.pop_front();
            m_rd0 = tmp;
         end
         if (wacc) q.push_back(wd);
      end
      @(posedge clk);
      #1;
      win = 1'b0; rout = 1'b0; flush = 1'b0;
      check_all();
   endtask

   // asynchronous reset pulse placed between edges
   task automatic do_reset();
      win = 1'b0; rout = 1'b0; flush = 1'b0;
      rst_n = 1'b0;
      #2;
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rd0 = 8'h00;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; flush = 1'b0; win = 1'b0; rout = 1'b0; wdata = 8'h00;
      m_ovf = 1'b0; m_unf = 1'b0; m_rd0 = 8'h00;
      #1;
      do_reset();

      // fill then overflow
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      chk("aempty_after_2", 32'(aempty0), 32'd0);
      step(1, 8'h33, 0, 0);
      chk("afull_after_3", 32'(afull0), 32'd1);
      step(1, 8'h44, 0, 0);
      chk("wfull_after_4", 32'(wfull0), 32'd1);
      step(1, 8'h55, 0, 0);
      chk("ovf_5th_write", 32'({ovf0, fcount0}), 32'({1'b1, 3'd4}));

      // drain, then underflow keeps last data
      for (int i = 0; i < 4; i++) begin
         step(0, 8'h00, 1, 0);
         chk("drain_data", 32'(rdata0), 32'(8'h11 * (i + 1)));
      end
      step(0, 8'h00, 1, 0);
      chk("underflow_hold", 32'({unf0, rempty0, rdata0}), 32'({1'b1, 1'b1, 8'h44}));

      // simultaneous read/write at count 2 and at full
      step(1, 8'hAA, 0, 0);
      step(1, 8'hBB, 0, 0);
      step(1, 8'hCC, 1, 0);
      chk("rw_at_2", 32'({fcount0, rdata0}), 32'({3'd2, 8'hAA}));
      step(1, 8'hDD, 0, 0);
      step(1, 8'hEE, 0, 0);
      step(1, 8'hFF, 1, 0);
      chk("rw_at_full", 32'({fcount0, ovf0, rdata0}), 32'({3'd3, 1'b1, 8'hBB}));

      // flush beats a same-cycle write
      step(1, 8'h77, 0, 1);
      chk("flush_state", 32'({fcount0, rempty0, ovf0, unf0}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));

      // wrap-around through interleaved pairs
      for (int i = 0; i < 10; i++) begin
         step(1, 8'(i), 0, 0);
         step(0, 8'h00, 1, 0);
         chk("wrap_data", 32'(rdata0), 32'(i));
      end

      // first-word fall-through
      step(1, 8'hA5, 0, 0);
      chk("fwft_head", 32'({rempty1, rdata1}), 32'({1'b0, 8'hA5}));
      step(0, 8'h00, 1, 0);
      chk("fwft_pop_empty", 32'(rempty1), 32'd1);

      // reset in the middle of a burst
      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      step(1, 8'h03, 1, 0);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic w, r, f;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         f = ($urandom_range(0, 63) == 0);
         step(w, 8'($urandom), r, f);
         if (i % 377 == 200) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter DSIZE, default 8: data width in bits.
REQ-002 Parameter ASIZE, default 4: address width; DEPTH = 2**ASIZE entries.
REQ-003 Parameter AFULL_TH, default DEPTH-2: almost-full threshold; legal range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 2: almost-empty threshold; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  the single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 flush  in  1  synchronous clear of pointers, count and flags.
REQ-010 wdata  in  DSIZE  write data.
REQ-011 win  in  1  write request.
REQ-012 wfull  out  1  FIFO holds DEPTH entries.
REQ-013 afull  out  1  fill count >= AFULL_TH.
REQ-014 rout  in  1  read (pop) request.
REQ-015 rdata  out  DSIZE  read data.
REQ-016 rempty  out  1  FIFO holds 0 entries.
REQ-017 aempty  out  1  fill count <= AEMPTY_TH.
REQ-018 fcount  out  ASIZE+1  current fill count, 0..DEPTH.
REQ-019 overflow  out  1  sticky: write attempted while full.
REQ-020 underflow  out  1  sticky: read attempted while empty.

Function
REQ-021 Storage: DEPTH x DSIZE array; write pointer and read pointer are ASIZE+1-bit binary counters; low ASIZE bits address the array; pointers wrap modulo 2*DEPTH.
REQ-022 Write accept: win=1 and wfull=0 at the edge -> wdata stored at write address, write pointer +1.
REQ-023 Read accept: rout=1 and rempty=0 at the edge -> read pointer +1.
REQ-024 Acceptance uses the flag values present before the edge; a simultaneous read does not unblock a write when full, and a simultaneous write does not unblock a read when empty.
REQ-025 fcount: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; it never leaves 0..DEPTH.
REQ-026 wfull, rempty, afull and aempty are registered, updated on the same edge as fcount, and always consistent with the new fcount.
REQ-027 FWFT=0: on an accepted read, rdata is loaded with the head entry at that edge (one-cycle latency); otherwise rdata holds its value.
REQ-028 FWFT=1: whenever rempty=0, rdata equals the head entry with no read request needed; an accepted read advances to the next entry in the following cycle; rdata is don't-care while rempty=1.
REQ-029 Rejected write (win=1, wfull=1): data is dropped, state is unchanged, and overflow is set to 1.
REQ-030 Rejected read (rout=1, rempty=1): state and rdata are unchanged, and underflow is set to 1.
REQ-031 overflow and underflow stay at 1 until reset or flush.
REQ-032 flush=1 has priority over win and rout in the same cycle: at that edge, pointers and fcount go to 0, rempty=1, aempty=1, wfull=0, afull=0 (1 if AFULL_TH=0 is not possible; afull is 0), and overflow and underflow are cleared.
REQ-033 flush leaves memory contents and rdata unchanged.

Reset
REQ-034 rst_n=0 immediately forces, without a clock: pointers=0, fcount=0, rempty=1, aempty=1, wfull=0, afull=0, overflow=0, underflow=0, rdata=0.
REQ-035 Reset asserted mid-operation discards all stored entries; the first edge after rst_n deasserts behaves as a cycle from the empty state.
REQ-036 Memory contents are not reset.

Verification (DSIZE=8, ASIZE=2, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-037 Fill: write 0x11, 0x22, 0x33, 0x44 -> fcount goes 1,2,3,4; aempty clears after the 2nd write; afull sets after the 3rd; wfull sets after the 4th; then a 5th write of 0x55 -> dropped, overflow=1, fcount=4.
REQ-038 Drain (FWFT=0): pop 4 times -> rdata = 0x11, 0x22, 0x33, 0x44, each one cycle after its pop; rempty=1 after the 4th; a 5th pop -> underflow=1, rdata stays 0x44.
REQ-039 Simultaneous write and read at fcount=2 -> fcount stays 2 and order is preserved; simultaneous write and read at full -> read accepted, write rejected, fcount=3, overflow=1.
REQ-040 Wrap-around: 10 interleaved write/read pairs with data 0x00..0x09 -> output sequence is 0x00..0x09 with no loss, and pointers wrap past 7 correctly.
REQ-041 FWFT=1: write 0xA5 into an empty FIFO -> rempty=0 and rdata=0xA5 the next cycle with no pop; pop -> rempty=1.
REQ-042 flush asserted together with win at fcount=3 and overflow=1 -> next cycle fcount=0, rempty=1, overflow=0, and the write is discarded; an asynchronous rst_n pulse mid-burst gives the same state without a clock edge.
